// File: rtl/wb_slave_pipelined_ram.sv
// Wishbone B4 pipelined RAM slave: responds LATENCY cycles after accept, ack/err strictly in order.
// Backpressure via stall_o for WAITCYCLES cycles per request; dropping cyc_i aborts all in flight.
module wb_slave_pipelined_ram #(
  parameter int DW         = 32,
  parameter int AW         = 16,
  parameter int DEPTH      = 2**AW,
  parameter int WAITCYCLES = 0,
  parameter int LATENCY    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            stall_o
);

  localparam int        IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int        NB = DW / 8;
  localparam logic [3:0] WC = 4'(WAITCYCLES);

  logic [DW-1:0]      mem [DEPTH];
  logic               valid;
  logic               accept;
  logic               in_range;
  logic [IW-1:0]      idx;
  logic [3:0]         wcnt;
  logic [LATENCY-1:0] p_ack;
  logic [LATENCY-1:0] p_err;
  logic [DW-1:0]      p_dat [LATENCY];

  assign valid    = cyc_i & stb_i;
  // With WAITCYCLES=0 the counter never leaves zero, so stall_o stays low.
  assign stall_o  = valid & (wcnt != WC);
  assign accept   = valid & ~stall_o;
  assign in_range = 32'(adr_i) < 32'(DEPTH);
  assign idx      = adr_i[IW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (!cyc_i || accept) begin
      wcnt <= '0;
    end else if (valid && stall_o) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_range && we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_i[b]) mem[idx][8*b +: 8] <= dat_i[8*b +: 8];
      end
    end
  end

  // Response pipeline; data is zeroed for writes and errors so dat_o is 0 unless a read acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_ack <= '0;
      p_err <= '0;
      for (int i = 0; i < LATENCY; i++) p_dat[i] <= '0;
    end else if (!cyc_i) begin
      p_ack <= '0;
      p_err <= '0;
      for (int i = 0; i < LATENCY; i++) p_dat[i] <= '0;
    end else begin
      p_ack[0] <= accept & in_range;
      p_err[0] <= accept & ~in_range;
      p_dat[0] <= (accept && in_range && !we_i) ? mem[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        p_ack[i] <= p_ack[i-1];
        p_err[i] <= p_err[i-1];
        p_dat[i] <= p_dat[i-1];
      end
    end
  end

  assign ack_o = p_ack[LATENCY-1];
  assign err_o = p_err[LATENCY-1];
  assign dat_o = p_dat[LATENCY-1];

endmodule

// File: tb/tb_wb_slave_pipelined_ram.sv
// Bench for wb_slave_pipelined_ram: two instances (no-wait/LAT1 and 2-wait/LAT3, DEPTH 1000)
// driven in turn; a scoreboard queue is checked by an independent negedge monitor.
module tb_wb_slave_pipelined_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [9:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic        act;

  logic [31:0] dat_o0, dat_o1;
  logic        ack0, ack1, err0, err1, stall0, stall1;
  logic        cyc0, cyc1;
  logic        ack, err, stall;
  logic [31:0] dato;

  assign cyc0  = cyc & ~act;
  assign cyc1  = cyc & act;
  assign ack   = act ? ack1 : ack0;
  assign err   = act ? err1 : err0;
  assign stall = act ? stall1 : stall0;
  assign dato  = act ? dat_o1 : dat_o0;

  wb_slave_pipelined_ram #(.DW(32), .AW(10), .DEPTH(1000), .WAITCYCLES(0), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .cyc_i(cyc0), .stb_i(stb), .we_i(we), .adr_i(adr), .sel_i(sel),
    .dat_i(dat), .dat_o(dat_o0), .ack_o(ack0), .err_o(err0), .stall_o(stall0));

  wb_slave_pipelined_ram #(.DW(32), .AW(10), .DEPTH(1000), .WAITCYCLES(2), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .cyc_i(cyc1), .stb_i(stb), .we_i(we), .adr_i(adr), .sel_i(sel),
    .dat_i(dat), .dat_o(dat_o1), .ack_o(ack1), .err_o(err1), .stall_o(stall1));

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] dat;
    logic [31:0] mask;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [2][1024];
  bit   [3:0]  kb [2][1024];
  int          tests = 0;
  int          fails = 0;
  int          cyc_cnt = 0;
  int          ack_seen = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory image, known-byte mask, fixed response delay.
  task automatic do_req(input bit w, input logic [9:0] a, input logic [3:0] s, input logic [31:0] d);
    int   nst = 0;
    exp_t e;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    @(negedge clk);
    while (stall && nst < 20) begin
      nst++;
      @(negedge clk);
    end
    chk("stall_cycles", 64'(nst), act ? 64'd2 : 64'd0);
    e.due  = cyc_cnt + (act ? 3 : 1);
    e.err  = (a >= 10'd1000);
    e.dat  = '0;
    e.mask = '1;
    if (!e.err) begin
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            mm[act][a][8*b +: 8] = d[8*b +: 8];
            kb[act][a][b] = 1'b1;
          end
        end
      end else begin
        e.dat = mm[act][a];
        for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{kb[act][a][b]}};
      end
    end
    q.push_back(e);
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (act ? (ack0 | err0 | (|dat_o0)) : (ack1 | err1 | (|dat_o1)))
        chk("idle_dut_quiet", 64'(act ? {ack0, err0, dat_o0} : {ack1, err1, dat_o1}), 64'd0);
      if (ack | err) begin
        ack_seen++;
        chk("ack_err_excl", 64'(ack & err), 64'd0);
        chk("resp_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("latency", 64'(cyc_cnt), 64'(e.due));
          chk("err_o", 64'(err), 64'(e.err));
          chk("ack_o", 64'(ack), 64'(!e.err));
          chk("dat_o", 64'(dato & e.mask), 64'(e.dat & e.mask));
        end
      end else begin
        chk("dat_idle", 64'(dato), 64'd0);
      end
      if (!cyc) q.delete();
    end
  end

  task automatic drain();
    cyc = 1'b1; stb = 1'b0;
    for (int k = 0; k < 30 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
    cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic expect_silence(input string nm, input int want);
    int s0 = ack_seen;
    repeat (8) @(posedge clk);
    #1;
    chk(nm, 64'(ack_seen - s0), 64'(want));
  endtask

  task automatic rand_req();
    logic [9:0] a;
    case ($urandom % 4)
      0:       a = 10'($urandom % 16);
      1:       a = 10'(990 + $urandom % 10);
      2:       a = 10'(1000 + $urandom % 24);
      default: a = 10'(16 + $urandom % 16);
    endcase
    do_req(1'($urandom % 2), a, ($urandom % 3 == 0) ? 4'hF : 4'($urandom), $urandom);
  endtask

  initial begin
    int r;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; act = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", 64'(ack0), 64'd0);
    chk("rst_err0", 64'(err0), 64'd0);
    chk("rst_dat0", 64'(dat_o0), 64'd0);
    chk("rst_ack1", 64'(ack1), 64'd0);
    chk("rst_err1", 64'(err1), 64'd0);
    chk("rst_dat1", 64'(dat_o1), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      act = 1'(d);
      do_req(1'b1, 10'h10, 4'hF, 32'hDEADBEEF);
      do_req(1'b0, 10'h10, 4'h0, 32'h0);
      do_req(1'b1, 10'd5, 4'hF, 32'h11223344);
      do_req(1'b1, 10'd5, 4'b0101, 32'hAABBCCDD);
      do_req(1'b0, 10'd5, 4'h0, 32'h0);
      do_req(1'b1, 10'd999, 4'hF, 32'hCAFEF00D);
      do_req(1'b0, 10'd1000, 4'hF, 32'h0);
      do_req(1'b1, 10'd1000, 4'hF, 32'h12345678);
      do_req(1'b0, 10'd999, 4'h0, 32'h0);
      drain();

      // Abort right after accept: LAT1 has already presented its ack, LAT3 must never respond.
      do_req(1'b0, 10'h10, 4'h0, 32'h0);
      cyc = 1'b0;
      expect_silence("abort_resp_count", d == 0 ? 1 : 0);

      for (int t = 0; t < 80; t++) begin
        rand_req();
        r = $urandom % 8;
        if (r == 0) begin
          cyc = 1'b0;
          repeat (1 + $urandom % 2) @(posedge clk);
          #1;
        end else if (r < 3) begin
          repeat (1 + $urandom % 2) @(posedge clk);
          #1;
        end
      end
      drain();
    end

    // Reset with a read still in flight in the LAT3 instance.
    act = 1'b1;
    do_req(1'b0, 10'h10, 4'h0, 32'h0);
    do_req(1'b0, 10'd5, 4'h0, 32'h0);
    do_req(1'b0, 10'd999, 4'h0, 32'h0);
    #1 rst = 1'b0;
    q.delete();
    cyc = 1'b0;
    #1;
    chk("midrst_ack1", 64'(ack1), 64'd0);
    chk("midrst_dat1", 64'(dat_o1), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    expect_silence("no_late_resp_lat3", 0);

    // Reset while the LAT1 instance is presenting an ack.
    act = 1'b0;
    do_req(1'b1, 10'd7, 4'hF, 32'h5A5A0FF0);
    do_req(1'b0, 10'd7, 4'h0, 32'h0);
    chk("pre_rst_ack0", 64'(ack0), 64'd1);
    #1 rst = 1'b0;
    q.delete();
    cyc = 1'b0;
    #1;
    chk("midrst_ack0", 64'(ack0), 64'd0);
    chk("midrst_dat0", 64'(dat_o0), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    expect_silence("no_late_resp_lat1", 0);

    // RAM contents survive reset.
    do_req(1'b0, 10'd7, 4'h0, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
